// File: rtl/gf2_digit_mult.sv
// ---------------------------------------------------------------------------
// gf2_digit_mult
//
// Digit-serial carry-less (GF(2)) polynomial multiplier with optional
// reduction modulo a fixed field polynomial.
//
// Each RUN cycle consumes DIGIT bits of b (least significant digit first)
// and XORs the corresponding partial product into a 2*WIDTH-bit accumulator.
// An operation takes N = ceil(WIDTH/DIGIT) RUN cycles. In reduce mode one
// extra RED cycle folds the accumulator down modulo POLY.
//
// Parameters
//   WIDTH  operand width in bits (2..1024)
//   DIGIT  bits of b consumed per cycle (1..WIDTH)
//   POLY   field polynomial, WIDTH+1 bits, bit WIDTH must be 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair and mode presented
//   in_ready   block idle and able to accept (IDLE only)
//   mode       0 = full unreduced product, 1 = product reduced mod POLY
//   a, b       operands, bit i = coefficient of x^i
//   out_valid  result on d is valid (DONE only)
//   out_ready  consumer accepts result
//   d          result, 2*WIDTH bits, driven straight from the accumulator
// ---------------------------------------------------------------------------
module gf2_digit_mult #(
    parameter int             WIDTH = 571,
    parameter int             DIGIT = 32,
    parameter logic [WIDTH:0] POLY  = ((WIDTH+1)'(1) << WIDTH) | (WIDTH+1)'(11'h425)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   d
);

    localparam int N  = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W2 = 2 * WIDTH;

    // POLY widened to accumulator width so it can be shifted into place.
    localparam logic [W2-1:0] POLY_EXT = {{(WIDTH-1){1'b0}}, POLY};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [W2-1:0]   acc_reg;
    // a pre-shifted by k*DIGIT: shifting once per cycle avoids a wide
    // variable barrel shifter on the partial product.
    logic [W2-1:0]   a_sh_reg;
    // b shifted right by DIGIT per cycle; the low DIGIT bits are the
    // current digit. Zeros shift in, so digit bits past WIDTH-1 read as 0.
    logic [WIDTH-1:0] b_sh_reg;
    logic            mode_reg;
    logic [CW-1:0]   cnt_reg;

    logic            last_digit;
    logic [W2-1:0]   pp;
    logic [W2-1:0]   red_val;

    assign last_digit = (cnt_reg == CW'(N - 1));

    // Carry-less product of the shifted multiplicand and the current digit.
    // The true product never exceeds 2*WIDTH-1 bits, so truncating to the
    // accumulator width loses nothing.
    always_comb begin
        pp = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (b_sh_reg[j]) begin
                pp = pp ^ (a_sh_reg << j);
            end
        end
    end

    // Full remainder mod POLY: clear each bit from 2*WIDTH-2 down to WIDTH
    // by XORing an aligned copy of POLY whenever that bit is set.
    always_comb begin
        red_val = acc_reg;
        for (int i = W2 - 2; i >= WIDTH; i--) begin
            if (red_val[i]) begin
                red_val = red_val ^ (POLY_EXT << (i - WIDTH));
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = mode_reg ? RED : DONE;
                end
            end
            RED: begin
                state_next = DONE;
            end
            DONE: begin
                // Leaving DONE lands in IDLE; the accept happens one edge later.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operands are captured only in IDLE, so input changes while
    // busy cannot disturb the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            mode_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg <= {{WIDTH{1'b0}}, a};
                        b_sh_reg <= b;
                        mode_reg <= mode;
                        acc_reg  <= '0;
                        cnt_reg  <= '0;
                    end
                end
                RUN: begin
                    acc_reg  <= acc_reg ^ pp;
                    a_sh_reg <= a_sh_reg << DIGIT;
                    b_sh_reg <= b_sh_reg >> DIGIT;
                    cnt_reg  <= cnt_reg + CW'(1);
                end
                RED: begin
                    acc_reg <= red_val;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign d         = acc_reg;

endmodule

// File: doc/gf2_digit_mult.md
GF2_DIGIT_MULT -- requirements
Module: gf2_digit_mult

Parameters
REQ-001 The block SHALL expose parameter WIDTH, default 571, giving the operand width in bits (legal range 2..1024).
REQ-002 The block SHALL expose parameter DIGIT, default 32, giving the bits of b consumed per cycle (legal range 1..WIDTH).
REQ-003 The block SHALL expose parameter POLY, WIDTH+1 bits, default x^571+x^10+x^5+x^2+1, giving the field polynomial used in reduce mode; bit WIDTH SHALL be 1.

Interface
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair and mode presented.
REQ-007 in_ready  output  1  block idle and able to accept.
REQ-008 mode  input  1  0 = full unreduced product; 1 = product reduced mod POLY.
REQ-009 a  input  WIDTH  multiplicand, GF(2) polynomial, bit i = coefficient of x^i.
REQ-010 b  input  WIDTH  multiplier, same encoding.
REQ-011 out_valid  output  1  result on d is valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 d  output  2*WIDTH  result; bit 2*WIDTH-1 always 0; in mode 1, bits above WIDTH-1 are 0.

Function
REQ-014 Arithmetic SHALL be carry-less (XOR accumulate); N = ceil(WIDTH/DIGIT) digit steps per operation.
REQ-015 States SHALL be IDLE, RUN, RED, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on an edge with in_valid=1, SHALL register a, b, mode, clear accumulator and digit counter, go to RUN; otherwise remain.
REQ-017 RUN: each edge SHALL XOR (a * b digit k) << (k*DIGIT) into the accumulator, k = counter, then increment the counter; digit bits beyond WIDTH-1 in the last digit SHALL be treated as 0.
REQ-018 RUN exit: on the edge that processes digit N-1, go to DONE if mode=0, else to RED.
REQ-019 RED: one edge SHALL replace the accumulator with its full remainder mod POLY (combinational fold from bit 2*WIDTH-2 down to WIDTH), then go to DONE.
REQ-020 Latency from accepting edge to out_valid SHALL be exactly N cycles (mode 0) or N+1 cycles (mode 1).
REQ-021 DONE: d SHALL hold stable until an edge with out_ready=1, which returns to IDLE; out_ready while not in DONE SHALL be ignored.
REQ-022 Throughput: no new operand SHALL be accepted on the edge that leaves DONE; the earliest next accept is the following edge.
REQ-023 Changes on a, b, mode, in_valid while not in IDLE SHALL have no effect on the result in flight.
REQ-024 d SHALL be driven only from the registered accumulator (no combinational path from inputs to outputs).
REQ-025 DIGIT = WIDTH (N = 1) SHALL be supported: one RUN cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, accumulator 0, counter 0, d = 0, out_valid = 0, in_ready = 1 (after release), regardless of state.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid SHALL follow release without a new accept.

Verification
REQ-028 WIDTH=8, DIGIT=3, POLY=0x11B, a=0x57, b=0x83, mode=0 -> out_valid 3 cycles after accept, d=0x2B79.
REQ-029 Same parameters, mode=1 -> out_valid 4 cycles after accept, d=0x00C1.
REQ-030 Defaults, a=2^570, b=2, mode=0 -> d=2^571 (bit 571 set only); mode=1 -> d=x^10+x^5+x^2+1=0x425.
REQ-031 WIDTH=143, DIGIT=143, random a, b, mode=0 -> d equals reference carry-less product after 1 cycle; b=0 -> d=0.
REQ-032 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> d stable, in_ready=0; then out_ready=1 -> IDLE next edge, new accept one edge later.
REQ-033 Assert rst_n low at RUN digit 1 -> out_valid=0, d=0 immediately; after release no out_valid until new accepted operation, which completes with correct result.
